// File: rtl/mem_access_unit.sv
// Memory access stage: picks a pointer as the RAM address and runs one read or
// write per MEMCtrl request edge. Read data lands in MEM_OUT with a rd_valid pulse.
module mem_access_unit #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        MEMCtrl,
  input  logic [1:0]        PCtrl,
  input  logic [ADDR_W-1:0] GSP_addr,
  input  logic [ADDR_W-1:0] RP_addr,
  input  logic [ADDR_W-1:0] CP_addr,
  input  logic [ADDR_W-1:0] STP_addr,
  input  logic [DATA_W-1:0] BUS_in,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_re,
  output logic              ram_we,
  output logic [DATA_W-1:0] MEM_OUT,
  output logic              rd_valid,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RD_CAP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t                   state, state_d;
  logic [1:0]               req_prev;
  logic [3:0]               cnt, cnt_d;
  logic [3:0][ADDR_W-1:0]   ptr;
  logic                     is_rd, is_wr, req_edge;
  logic [ADDR_W-1:0]        addr_d;
  logic [DATA_W-1:0]        wdata_d, mem_out_d;
  logic                     re_d, we_d, rdv_d, busy_d, ovr_d;

  assign ptr      = {STP_addr, CP_addr, RP_addr, GSP_addr};
  assign is_rd    = (MEMCtrl == 2'b01);
  assign is_wr    = (MEMCtrl == 2'b10);
  // code 11 is neither read nor write, so it can never form an edge
  assign req_edge = (is_rd || is_wr) && (MEMCtrl != req_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_prev  <= 2'b00;
      cnt       <= 4'd0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_re    <= 1'b0;
      ram_we    <= 1'b0;
      MEM_OUT   <= '0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_d;
      req_prev  <= MEMCtrl;
      cnt       <= cnt_d;
      ram_addr  <= addr_d;
      ram_wdata <= wdata_d;
      ram_re    <= re_d;
      ram_we    <= we_d;
      MEM_OUT   <= mem_out_d;
      rd_valid  <= rdv_d;
      busy      <= busy_d;
      overrun   <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    addr_d    = ram_addr;
    wdata_d   = ram_wdata;
    mem_out_d = MEM_OUT;
    re_d      = 1'b0;
    we_d      = 1'b0;
    rdv_d     = 1'b0;
    busy_d    = busy;
    // the busy-falling edge still counts as busy, so only IDLE accepts
    ovr_d     = overrun | (req_edge && (state != IDLE));
    case (state)
      IDLE: begin
        if (req_edge) begin
          addr_d = ptr[PCtrl];
          busy_d = 1'b1;
          if (is_rd) begin
            re_d    = 1'b1;
            cnt_d   = WAIT_INIT;
            state_d = RD_WAIT;
          end else begin
            wdata_d = BUS_in;
            we_d    = 1'b1;
            state_d = WR;
          end
        end
      end
      WR: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      RD_WAIT: begin
        cnt_d = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = RD_CAP;
        end
      end
      RD_CAP: begin
        mem_out_d = ram_rdata;
        rdv_d     = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side stage directly downstream of the control unit.
- Consumes the control unit's MEMCtrl and PCtrl.
- Selects the RAM address from one of four pointer registers (GSP, RP, CP, STP) and sequences a single RAM read or write per request.
- Returns read data in the MEM_OUT register, which drives the BS_MEMOUT bus source, and reports busy and overrun status.

Parameters:
- ADDR_W, 12, width of the pointer registers and the RAM address.
- DATA_W, 16, width of the data bus, the RAM data and MEM_OUT.
- WAIT_CYCLES, 1, RAM read latency in clocks after ram_re is sampled by the RAM. Legal range is 1..15.

Ports:
- clk  in  1  system clock; this block uses the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- MEMCtrl  in  2  00 idle, 01 read, 10 write, 11 reserved (treated as idle).
- PCtrl  in  2  address source: 00 GSP, 01 RP, 10 CP, 11 STP.
- GSP_addr  in  ADDR_W  general-purpose pointer.
- RP_addr  in  ADDR_W  row pointer.
- CP_addr  in  ADDR_W  column pointer.
- STP_addr  in  ADDR_W  store pointer.
- BUS_in  in  DATA_W  write data (the AC value on the bus).
- ram_rdata  in  DATA_W  RAM read data.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_wdata  out  DATA_W  registered RAM write data.
- ram_re  out  1  RAM read strobe, one cycle.
- ram_we  out  1  RAM write strobe, one cycle.
- MEM_OUT  out  DATA_W  last read data, held until the next read completes.
- rd_valid  out  1  one-cycle pulse after MEM_OUT updates.
- busy  out  1  high while an access is in progress.
- overrun  out  1  sticky; set when a request edge arrives while busy.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - ram_addr=0, ram_wdata=0, ram_re=0, ram_we=0.
  - MEM_OUT=0, rd_valid=0, busy=0, overrun=0.
  - req_prev=idle, wait counter=0.
- Request detection:
  - MEMCtrl is sampled every rising edge into req_prev.
  - A request edge is a sampled value of 01 or 10 that differs from req_prev.
  - A request held for multiple cycles produces exactly one access.
  - Code 11 is treated exactly like 00 and never triggers an access.
- IDLE, on a request edge at edge N:
  - Latch ram_addr = mux(PCtrl) as sampled at edge N.
  - Set busy=1.
  - Read: ram_re=1, counter=WAIT_CYCLES, go to RD_WAIT.
  - Write: ram_wdata=BUS_in, ram_we=1, go to WR.
- WR, at edge N+1: ram_we=0, busy=0, go to IDLE. A write therefore occupies exactly 1 cycle.
- RD_WAIT, each edge:
  - ram_re=0 and the counter decrements.
  - When the counter reaches 0, go to RD_CAP.
  - For WAIT_CYCLES=1 this state occupies one edge, N+1.
- RD_CAP, at edge N+1+WAIT_CYCLES:
  - MEM_OUT=ram_rdata, rd_valid=1, busy=0, go to IDLE.
  - rd_valid clears on the following edge.
- Latency: total read latency from the sampling edge to the MEM_OUT update is WAIT_CYCLES+1 edges.
- Requests while busy:
  - Any request edge in WR, RD_WAIT or RD_CAP is dropped, not queued, and sets overrun=1.
  - req_prev still updates.
  - overrun clears only on reset.
- Pointer and data changes: changes to PCtrl, the pointers or BUS_in after the sampling edge do not affect the access in flight.
- Simultaneity: a request edge at the same edge on which busy falls (the WR or RD_CAP edge) counts as busy, so it is dropped and flagged.
- Reset mid-access: ram_re and ram_we drop immediately (asynchronous) and MEM_OUT returns to 0. After release, no access resumes even if MEMCtrl is still non-idle, because req_prev was reset to idle. A non-idle MEMCtrl at the first edge after release is treated as a new request edge.
- Address width: pointers are used as-is with no arithmetic; wrap-around belongs to the pointer registers.

Test Plan:
- Read with defaults: GSP_addr=0x010, RAM[0x010]=0xBEEF; MEMCtrl=01 and PCtrl=00 for one cycle.
  - Required: ram_re high one cycle, ram_addr=0x010.
  - Required: MEM_OUT=0xBEEF and rd_valid pulse 2 edges after sampling; busy high for exactly those 2 cycles.
- Write: STP_addr=0x3FF, BUS_in=0x1234; MEMCtrl=10 and PCtrl=11.
  - Required: ram_we high exactly one cycle with ram_addr=0x3FF and ram_wdata=0x1234; RAM[0x3FF]=0x1234 afterwards.
- Address select: issue reads with PCtrl=00, 01, 10, 11 and pointers 0x001, 0x002, 0x003, 0x004.
  - Required: ram_addr equals 0x001, 0x002, 0x003, 0x004 respectively.
- Held and reserved codes: MEMCtrl=01 held 5 cycles, then 11 held 3 cycles.
  - Required: exactly one ram_re pulse; no ram_re/ram_we during the 11 code.
- Overrun with WAIT_CYCLES=3: a read edge, then a write edge 2 cycles later.
  - Required: no ram_we, overrun=1 and stays 1; the read still completes with correct MEM_OUT.
- Reset mid-read: assert rst_n=0 during RD_WAIT.
  - Required: ram_re=0, busy=0, MEM_OUT=0 immediately.
  - Required: after release with MEMCtrl held at 01, one new read starts at the first edge.
